// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side drain controller.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_HALT  = 2'd2
    } rd_state_e;

    localparam int unsigned SKID_DEPTH = 3;
    localparam int unsigned OCC_W      = 2;
    localparam int unsigned PTR_W      = 2;

    // A zero timeout still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(SKID_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Three-entry in-order register FIFO absorbing the FIFO's read latency.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DW = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             rd_i,
    output logic [OCC_W-1:0] occ_o,
    output logic [DW-1:0]    head_data_o,
    output logic             head_valid_o
);

    logic [DW-1:0]    mem_q [SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             rd_fire;

    assign rd_fire = rd_i & (occ_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_fire) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({wr_i, rd_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ_o        = occ_q;
    assign head_data_o  = mem_q[rd_ptr_q];
    assign head_valid_o = (occ_q != '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO controller: burst/timeout drain FSM, credit-limited pop, skid output.
module fifo_drain_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int unsigned data_width     = 10,
    parameter int unsigned timeout_cycles = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] FIFO_data_out,
    input  logic                  empty_fifo,
    input  logic                  almost_empty_fifo,
    input  logic                  error,
    output logic                  pop,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  drain_active,
    output logic                  err_sticky
);

    localparam int unsigned          CW         = cnt_width(timeout_cycles);
    localparam logic [CW-1:0]        CNT_MAX    = CW'(timeout_cycles);
    localparam logic [OCC_W:0]       CREDIT_MAX = (OCC_W + 1)'(SKID_DEPTH);

    rd_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             inflight_q;
    logic             err_q;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   credit_used;

    assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= pop;
            err_q      <= err_q | error;
        end
    end

    // The timeout compares the post-increment count so the first non-empty cycle counts as 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (error) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (empty_fifo) begin
                        cnt_d = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (!empty_fifo && (!almost_empty_fifo || cnt_d == CNT_MAX)) begin
                        state_d = ST_BURST;
                    end
                end
                ST_BURST: begin
                    pop = !empty_fifo && (credit_used < CREDIT_MAX);
                    if (empty_fifo) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    rd_skid_buf #(
        .DW (data_width)
    ) u_skid (
        .clk          (clk),
        .rst_n        (reset),
        .wr_i         (inflight_q),
        .wr_data_i    (FIFO_data_out),
        .rd_i         (valid_out & ready_in),
        .occ_o        (occ),
        .head_data_o  (data_out),
        .head_valid_o (valid_out)
    );

    assign drain_active = (state_q == ST_BURST);
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl with a FIFO model and an in-order scoreboard.
module tb_fifo_drain_ctrl;

    localparam int DW   = 10;
    localparam int TO   = 16;
    localparam int BAJO = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] FIFO_data_out;
    logic          empty_fifo;
    logic          almost_empty_fifo;
    logic          error;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic          drain_active;
    logic          err_sticky;

    logic          err_inj = 1'b0;
    logic          uf_q = 1'b0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] w;
    int level = 0;
    int occ_m = 0;
    int infl_m = 0;
    int cyc = 0;
    int passes = 0;
    int checks = 0;
    int delivered = 0;
    int npop = 0;
    int first_pop = -1;
    int first_valid = -1;
    int last_valid = -1;

    always #5 clk = ~clk;

    assign empty_fifo        = (level == 0);
    assign almost_empty_fifo = (level <= BAJO);
    assign error             = err_inj | uf_q;

    fifo_drain_ctrl #(
        .data_width     (DW),
        .timeout_cycles (TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .FIFO_data_out     (FIFO_data_out),
        .empty_fifo        (empty_fifo),
        .almost_empty_fifo (almost_empty_fifo),
        .error             (error),
        .pop               (pop),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .ready_in          (ready_in),
        .drain_active      (drain_active),
        .err_sticky        (err_sticky)
    );

    // FIFO with registered read data/flags, plus expected skid occupancy and in-flight flag
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fq.delete();
            level         <= 0;
            FIFO_data_out <= '0;
            occ_m         <= 0;
            infl_m        <= 0;
            uf_q          <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (pop) begin
                if (fq.size() == 0) uf_q <= 1'b1;
                else FIFO_data_out <= fq.pop_front();
            end
            level  <= fq.size();
            occ_m  <= occ_m + infl_m - ((valid_out && ready_in) ? 1 : 0);
            infl_m <= pop ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (valid_out !== (occ_m != 0)) $display("FAIL valid_vs_occ: valid_out=%0b expected %0b (cycle %0d)", valid_out, (occ_m != 0), cyc);
            else passes++;
            if (pop) begin
                npop++;
                if (first_pop < 0) first_pop = cyc;
                checks++;
                if (empty_fifo || (occ_m + infl_m >= 3)) $display("FAIL pop_credit: pop=1 with empty=%0b occ+inflight=%0d, required pop=0", empty_fifo, occ_m + infl_m);
                else passes++;
            end
            if (valid_out && ready_in) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                delivered++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL sb_extra: got word %0h, expected no word", data_out);
                else begin
                    w = exp_q.pop_front();
                    if (data_out !== w) $display("FAIL sb_data: got %0h expected %0h", data_out, w);
                    else passes++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(DW'(base + i));
            exp_q.push_back(DW'(base + i));
        end
    endtask

    task automatic clear_stats();
        delivered = 0; npop = 0; first_pop = -1; first_valid = -1; last_valid = -1;
    endtask

    task automatic do_reset();
        reset = 1'b0; err_inj = 1'b0; ready_in = 1'b0;
        exp_q.delete();
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; err_inj = 1'b0; ready_in = 1'b0;
        #3;
        checks++; if (pop !== 1'b0) $display("FAIL rst_pop: got %0b expected 0", pop); else passes++;
        checks++; if (valid_out !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", valid_out); else passes++;
        checks++; if (data_out !== '0) $display("FAIL rst_data: got %0h expected 0", data_out); else passes++;
        checks++; if (drain_active !== 1'b0) $display("FAIL rst_drain: got %0b expected 0", drain_active); else passes++;
        checks++; if (err_sticky !== 1'b0) $display("FAIL rst_err: got %0b expected 0", err_sticky); else passes++;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_burst();
        int k;
        bit done;
        clear_stats();
        ready_in = 1'b1;
        push_words(10, 'h100);
        k = cyc;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            if (delivered == 10 && !drain_active && !valid_out) done = 1;
        end
        checks++; if (!done) $display("FAIL burst_timeout: delivered %0d expected 10", delivered); else passes++;
        checks++; if (first_pop != k + 2) $display("FAIL burst_start: first pop cycle %0d expected %0d", first_pop, k + 2); else passes++;
        checks++; if (npop != 10) $display("FAIL burst_pops: got %0d expected 10", npop); else passes++;
        checks++; if (first_valid - first_pop != 2) $display("FAIL burst_latency: got %0d expected 2", first_valid - first_pop); else passes++;
        checks++; if (last_valid - first_valid != 9) $display("FAIL burst_rate: span %0d expected 9", last_valid - first_valid); else passes++;
        checks++; if (drain_active !== 1'b0) $display("FAIL burst_idle: drain_active %0b expected 0", drain_active); else passes++;
        checks++; if (uf_q !== 1'b0) $display("FAIL burst_underflow: fifo error %0b expected 0", uf_q); else passes++;
        checks++; if (err_sticky !== 1'b0) $display("FAIL burst_err: err_sticky %0b expected 0", err_sticky); else passes++;
    endtask

    task automatic test_timeout();
        int cnt;
        bit done;
        clear_stats();
        ready_in = 1'b1;
        push_words(2, 'h200);
        cnt = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!empty_fifo) cnt++;
            if (pop) done = 1;
        end
        checks++; if (!done || cnt != TO + 1) $display("FAIL timeout_first_pop: pop in non-empty cycle %0d expected %0d", cnt, TO + 1); else passes++;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (delivered == 2 && !drain_active && !valid_out) done = 1;
        end
        checks++; if (delivered != 2) $display("FAIL timeout_words: got %0d expected 2", delivered); else passes++;
        checks++; if (drain_active !== 1'b0) $display("FAIL timeout_idle: drain_active %0b expected 0", drain_active); else passes++;
    endtask

    task automatic test_back_to_back();
        bit done;
        clear_stats();
        push_words(12, 'h300);
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            ready_in = (k % 4 == 0);
            step();
            if (delivered == 12 && !drain_active) done = 1;
        end
        ready_in = 1'b1;
        repeat (3) step();
        checks++; if (delivered != 12) $display("FAIL bp_words: got %0d expected 12", delivered); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL bp_left: %0d words outstanding expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_error();
        bit hit;
        clear_stats();
        ready_in = 1'b0;
        push_words(10, 'h180);
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (occ_m == 2 && infl_m == 1) hit = 1;
        end
        checks++; if (!hit) $display("FAIL err_setup: occ %0d inflight %0d expected 2/1", occ_m, infl_m); else passes++;
        err_inj = 1'b1;
        #1;
        checks++; if (pop !== 1'b0) $display("FAIL err_pop_same_cycle: got %0b expected 0", pop); else passes++;
        step();
        err_inj = 1'b0;
        npop = 0;
        checks++; if (err_sticky !== 1'b1) $display("FAIL err_sticky: got %0b expected 1", err_sticky); else passes++;
        checks++; if (drain_active !== 1'b0) $display("FAIL err_halt: drain_active %0b expected 0", drain_active); else passes++;
        repeat (5) step();
        ready_in = 1'b1;
        repeat (10) step();
        checks++; if (npop != 0) $display("FAIL err_no_pop: got %0d pops expected 0", npop); else passes++;
        checks++; if (delivered != 3) $display("FAIL err_drain: got %0d words expected 3", delivered); else passes++;
        checks++; if (drain_active !== 1'b0 || err_sticky !== 1'b1) $display("FAIL err_stays_halt: drain %0b sticky %0b expected 0/1", drain_active, err_sticky); else passes++;
    endtask

    task automatic test_reset_mid_burst();
        bit hit;
        do_reset();
        clear_stats();
        ready_in = 1'b0;
        push_words(10, 'h240);
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (occ_m == 2) hit = 1;
        end
        checks++; if (!hit || drain_active !== 1'b1) $display("FAIL rmid_setup: occ %0d drain %0b expected 2/1", occ_m, drain_active); else passes++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0 || pop !== 1'b0) $display("FAIL rmid_clear: valid %0b pop %0b expected 0/0", valid_out, pop); else passes++;
        checks++; if (err_sticky !== 1'b0 || drain_active !== 1'b0) $display("FAIL rmid_flags: sticky %0b drain %0b expected 0/0", err_sticky, drain_active); else passes++;
        exp_q.delete();
        step();
        reset = 1'b1;
        step();
        clear_stats();
        ready_in = 1'b1;
        push_words(5, 'h2a0);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (delivered == 5 && !drain_active && !valid_out) hit = 1;
        end
        checks++; if (delivered != 5) $display("FAIL rmid_resume: got %0d words expected 5", delivered); else passes++;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_timeout();
        test_back_to_back();
        test_error();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side controller for the 10-bit data FIFO: it decides when to pop, absorbs the FIFO's registered read latency, and presents words downstream on a valid/ready handshake. It sits between the FIFO outputs (`FIFO_data_out`, `empty_fifo`, `almost_empty_fifo`, `error`) and the consuming logic, and drives the FIFO's `pop` input. The complementary writer already drives `push`. Popping is burst-oriented: draining starts once the `bajo` threshold is crossed or an idle timeout expires.

## Interface
- `data_width`, 10, FIFO word width.
- `timeout_cycles`, 16, number of IDLE cycles with a non-empty FIFO before a forced drain; 0 means drain immediately.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `FIFO_data_out` in `data_width`: FIFO read data, valid the cycle after `pop` is sampled.
- `empty_fifo` in 1: registered FIFO empty flag; it already reflects pops from the prior cycle.
- `almost_empty_fifo` in 1: FIFO level ≤ `bajo`.
- `error` in 1: FIFO overflow/underflow indication.
- `pop` out 1: FIFO read strobe.
- `data_out` out `data_width`: word presented downstream.
- `valid_out` out 1: `data_out` is valid.
- `ready_in` in 1: downstream accepts when `valid_out & ready_in`.
- `drain_active` out 1: FSM is in BURST.
- `err_sticky` out 1: FIFO `error` was seen.

## Operation
- **Reset values:** `pop` = 0, `valid_out` = 0, `data_out` = 0, `drain_active` = 0, `err_sticky` = 0. State = IDLE. Skid occupancy = 0, in-flight = 0, timeout counter = 0.
- **Skid buffer:**
  - 3 entries, in-order.
  - `occ` is the current occupancy; `inflight` is 1 if `pop` was high in the previous cycle.
- **Credit rule:** `pop = (state == BURST) & !empty_fifo & (occ + inflight < 3)`. This rule guarantees no skid overflow and no pop while empty.
- **FSM states:**
  - **IDLE:**
    - Timeout counter increments while `!empty_fifo` and saturates at `timeout_cycles`; it clears when `empty_fifo`.
    - Go to BURST when `!empty_fifo & (!almost_empty_fifo | count == timeout_cycles)`.
  - **BURST:**
    - Pop per credit rule; `drain_active` = 1.
    - Go to IDLE when `empty_fifo` (counter cleared).
  - **HALT:**
    - Entered from any state when `error` = 1; `err_sticky` is set.
    - `pop` forced to 0.
    - In-flight word is still captured and the skid still drains downstream.
    - Exit only via `reset`.
- **Capture:** when `inflight` = 1, `FIFO_data_out` is written into the skid tail at that edge.
- **Output:**
  - `data_out` and `valid_out` come from the skid head, registered.
  - Head advances on `valid_out & ready_in`.
  - Capture and dequeue in the same cycle leave `occ` unchanged.
- **`ready_in` low:** the skid fills to 3 and `pop` stops; words are never dropped or duplicated.

## Timing
- `pop` at cycle t → data captured at the end of t+1 → `valid_out` in cycle t+2. Latency is 2 cycles.
- With `ready_in` held high and a non-empty FIFO, throughput is 1 word/cycle after the 2-cycle fill.
- Timeout: first IDLE cycle with `!empty_fifo` and `almost_empty_fifo` counts as 1. BURST is entered at the edge after the count reaches `timeout_cycles`, and the first `pop` follows in the next cycle.
- `empty_fifo` rising in BURST: `pop` drops the same cycle (combinational on the flag); BURST → IDLE at that edge.
- `error` in the same cycle as a pop request: `pop` = 0 that cycle (HALT has priority).
- Asynchronous `reset` mid-burst: all state is cleared immediately and the skid contents are discarded. The in-flight FIFO read is lost; the FIFO is reset in the same domain.

## Structure
- **Shared package `fifo_rd_pkg`:**
  - State encoding (IDLE, BURST, HALT).
  - `SKID_DEPTH` = 3.
  - Counter width derived as clog2(`timeout_cycles` + 1).
- **Sub-module `rd_skid_buf`:**
  - 3-entry register FIFO with write/read strobes, `occ` output, and head data/valid.
- **Top level:** FSM, timeout counter, credit logic, in-flight flag.

## Test plan
- FIFO preloaded with 10 words, level above `bajo`, `ready_in` = 1 → BURST next cycle. Exactly 10 pops, words 0..9 appear in order, first `valid_out` 2 cycles after first `pop`, 1 word/cycle, return to IDLE.
- 2 words written, `almost_empty_fifo` = 1, `timeout_cycles` = 16 → no `pop` for 16 cycles, then BURST, 2 words out, IDLE.
- Burst with `ready_in` toggling (high 1, low 3) → `occ` never exceeds 3, `pop` never asserted with `occ + inflight` = 3, output sequence lossless.
- Last word popped, `empty_fifo` rises → no `pop` while `empty_fifo`, FIFO `error` stays 0, `drain_active` falls.
- `error` pulsed mid-burst with 2 words in the skid → `pop` = 0 from that cycle, `err_sticky` = 1, the 2 buffered words plus the in-flight word still delivered, FSM stays in HALT.
- `reset` asserted mid-burst with `occ` = 2 → `valid_out`, `pop`, `err_sticky` = 0 immediately. After release, normal drain resumes from a refilled FIFO.
